// File: rtl/fb_arbiter.sv
// fb_arbiter: shares a single-port framebuffer RAM between VGA scanout
// (phase-0 slot, fixed 2-cycle read latency) and the CPU load/store port.
// Ports:
//   clk, reset                  - 50 MHz clock, synchronous active-high reset
//   vga_slot                    - high in phase 0; VGA may request only then
//   vga_req/vga_addr            - VGA read request and address
//   vga_rdata/vga_rvalid        - VGA read data and its one-cycle valid pulse
//   vga_err                     - sticky: VGA requested outside its slot
//   cpu_req/we/addr/wdata       - CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata           - CPU completion pulse and read data
//   mem_en/we/addr/wdata/rdata  - single-port synchronous RAM interface
module fb_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              vga_slot,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_err,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RDWAIT,
        DONE
    } state_t;

    state_t              state_q;
    logic                phase_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                vga_p1_q;
    logic                vga_rvalid_q;
    logic [DATA_W-1:0]   vga_rdata_q;
    logic                vga_err_q;
    logic                cpu_ack_q;
    logic [DATA_W-1:0]   cpu_rdata_q;

    logic                vga_grant;
    logic                cpu_grant;

    assign vga_slot  = ~phase_q;
    assign vga_grant = vga_slot & vga_req;
    // VGA always wins its own slot; the CPU takes whatever is left.
    assign cpu_grant = (state_q == PEND) & ~vga_grant;

    // RAM drive is held off during reset regardless of grant state.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (vga_grant) begin
                mem_en   = 1'b1;
                mem_addr = vga_addr;
            end else if (cpu_grant) begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            vga_p1_q     <= 1'b0;
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            vga_err_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            phase_q      <= ~phase_q;
            // Two-stage return: RAM data lands in N+1, rvalid shows in N+2.
            vga_p1_q     <= vga_grant;
            vga_rvalid_q <= vga_p1_q;
            if (vga_p1_q) begin
                vga_rdata_q <= mem_rdata;
            end
            if (vga_req && !vga_slot) begin
                vga_err_q <= 1'b1;
            end
            cpu_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (cpu_grant) begin
                        if (we_q) begin
                            state_q   <= DONE;
                            cpu_ack_q <= 1'b1;
                        end else begin
                            state_q <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    cpu_rdata_q <= mem_rdata;
                    cpu_ack_q   <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vga_rdata  = vga_rdata_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_err    = vga_err_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed test of fb_arbiter with a behavioural
// single-port synchronous RAM preloaded with mem[a] = a[7:0].
module tb_fb_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              vga_slot;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              vga_err;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int checks;
    int errors;
    logic exp_phase;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .reset(reset),
        .vga_slot(vga_slot),
        .vga_req(vga_req),
        .vga_addr(vga_addr),
        .vga_rdata(vga_rdata),
        .vga_rvalid(vga_rvalid),
        .vga_err(vga_err),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; phase model follows reset as sampled at the edge.
    task automatic step();
        logic r;
        logic s;
        r = reset;
        @(posedge clk);
        #1;
        exp_phase = r ? 1'b0 : ~exp_phase;
        s = ~exp_phase;
        chk("vga_slot", vga_slot, s);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_phase = 1'b0;
        mem_rdata = '0;
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = a[7:0];
        reset = 1'b1;
        vga_req = 1'b0;
        vga_addr = '0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;

        // reset for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
        end
        chk("rst_rvalid", vga_rvalid, 0);
        chk("rst_err", vga_err, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_vga_rdata", vga_rdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);

        reset = 1'b0;
        settle();
        chk("slot_first", vga_slot, 1);
        step();
        step();
        step();
        chk("idle_mem_en", mem_en, 0);
        step();

        // VGA fetch every slot from 0x00010
        for (int i = 0; i < 3; i++) begin
            vga_req = 1'b1;
            vga_addr = 17'h00010;
            settle();
            chk("vga_mem_en", mem_en, 1);
            chk("vga_mem_we", mem_we, 0);
            chk("vga_mem_addr", mem_addr, 32'h10);
            if (i > 0) begin
                chk("vga_rvalid_hi", vga_rvalid, 1);
                chk("vga_rdata", vga_rdata, 32'h10);
            end else begin
                chk("vga_rvalid_first", vga_rvalid, 0);
            end
            step();
            vga_req = 1'b0;
            settle();
            chk("vga_rvalid_lo", vga_rvalid, 0);
            chk("vga_off_mem_en", mem_en, 0);
            step();
        end
        chk("vga_rvalid_last", vga_rvalid, 1);
        chk("vga_rdata_last", vga_rdata, 32'h10);
        chk("vga_err_none", vga_err, 0);
        step();

        // CPU write 0xA5 -> 0x01234 in phase 1
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 17'h01234;
        cpu_wdata = 8'hA5;
        settle();
        chk("wr_req_ack", cpu_ack, 0);
        chk("wr_req_mem_en", mem_en, 0);
        step();
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h1234);
        chk("wr_mem_wdata", mem_wdata, 32'hA5);
        chk("wr_ack_early", cpu_ack, 0);
        step();
        chk("wr_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        step();
        chk("wr_ack_once", cpu_ack, 0);

        // CPU read back 0x01234
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 17'h01234;
        step();
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 32'h1234);
        step();
        chk("rd_wait_mem_en", mem_en, 0);
        chk("rd_wait_ack", cpu_ack, 0);
        step();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_data", cpu_rdata, 32'hA5);
        cpu_req = 1'b0;
        step();
        chk("rd_ack_once", cpu_ack, 0);
        chk("rd_data_held", cpu_rdata, 32'hA5);
        step();

        // CPU read blocked by VGA in phase 0
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 17'h00033;
        step();
        vga_req = 1'b1;
        vga_addr = 17'h00020;
        settle();
        chk("blk_vga_wins_addr", mem_addr, 32'h20);
        chk("blk_vga_wins_we", mem_we, 0);
        step();
        vga_req = 1'b0;
        settle();
        chk("blk_cpu_en", mem_en, 1);
        chk("blk_cpu_addr", mem_addr, 32'h33);
        step();
        chk("blk_vga_rvalid", vga_rvalid, 1);
        chk("blk_vga_rdata", vga_rdata, 32'h20);
        chk("blk_ack_early", cpu_ack, 0);
        step();
        chk("blk_ack", cpu_ack, 1);
        chk("blk_rdata", cpu_rdata, 32'h33);
        chk("blk_rvalid_lo", vga_rvalid, 0);
        cpu_req = 1'b0;
        step();

        // VGA reads the CPU-written word
        vga_req = 1'b1;
        vga_addr = 17'h01234;
        step();
        vga_req = 1'b0;
        step();
        chk("raw_vga_rvalid", vga_rvalid, 1);
        chk("raw_vga_rdata", vga_rdata, 32'hA5);
        step();

        // VGA request outside its slot
        vga_req = 1'b1;
        vga_addr = 17'h00040;
        settle();
        chk("err_no_mem_en", mem_en, 0);
        step();
        vga_req = 1'b0;
        settle();
        chk("err_set", vga_err, 1);
        chk("err_rvalid0", vga_rvalid, 0);
        step();
        chk("err_rvalid1", vga_rvalid, 0);
        chk("err_sticky", vga_err, 1);
        step();

        // reset during RDWAIT of a CPU read
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 17'h00055;
        vga_req = 1'b1;
        vga_addr = 17'h00010;
        settle();
        chk("rr_vga_addr", mem_addr, 32'h10);
        step();
        vga_req = 1'b0;
        settle();
        chk("rr_cpu_addr", mem_addr, 32'h55);
        chk("rr_cpu_en", mem_en, 1);
        step();
        reset = 1'b1;
        cpu_req = 1'b0;
        vga_req = 1'b1;
        settle();
        chk("rr_mem_en_rst", mem_en, 0);
        chk("rr_err_pre", vga_err, 1);
        step();
        chk("rr_ack", cpu_ack, 0);
        chk("rr_rvalid", vga_rvalid, 0);
        chk("rr_cpu_rdata", cpu_rdata, 0);
        chk("rr_vga_rdata", vga_rdata, 0);
        chk("rr_err_clr", vga_err, 0);
        chk("rr_mem_en_rst2", mem_en, 0);
        step();
        chk("rr_mem_en_rst3", mem_en, 0);
        chk("rr_ack2", cpu_ack, 0);
        reset = 1'b0;
        vga_req = 1'b0;

        // FSM back in IDLE: a write completes in 2 cycles
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 17'h00077;
        cpu_wdata = 8'h5A;
        settle();
        chk("post_ack0", cpu_ack, 0);
        step();
        chk("post_mem_we", mem_we, 1);
        chk("post_mem_addr", mem_addr, 32'h77);
        chk("post_mem_wdata", mem_wdata, 32'h5A);
        step();
        chk("post_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
